// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer/checker.
// Holds the FSM state encoding, the NZCV bit positions and the queue entry layout.
package cpu_pkg;

  localparam int unsigned Q_INSTR_W = 32;
  localparam int unsigned Q_DATA_W  = 32;
  localparam int unsigned NZCV_W    = 4;

  // NZCV occupies the top nibble of the cpu status word.
  localparam int unsigned NZCV_HI   = 31;
  localparam int unsigned NZCV_LO   = 28;

  localparam int unsigned CHK_DATA  = 0;
  localparam int unsigned CHK_FLAGS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_FIN
  } seq_state_e;

  typedef struct packed {
    logic [Q_INSTR_W-1:0] instr;
    logic [Q_DATA_W-1:0]  exp_data;
    logic [NZCV_W-1:0]    exp_flags;
    logic [1:0]           chk;
  } q_entry_t;

endpackage

// File: rtl/seq_fifo.sv
// Circular-buffer FIFO with occupancy count; push when full and pop when empty are dropped.
// DEPTH must be a power of two so the pointers wrap naturally.
module seq_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_c;
  logic             pop_ok_c;

  always_comb begin
    push_ok_c = push & ~full_q;
    pop_ok_c  = pop & ~empty_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (push_ok_c) wr_d = wr_q + PTR_W'(1);
    if (pop_ok_c)  rd_d = rd_q + PTR_W'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = cnt_q + LVL_W'(1);
      2'b01:   cnt_d = cnt_q - LVL_W'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == LVL_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign level = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/instr_seq_checker.sv
// Issues queued instructions to the cpu one at a time and checks datapath/NZCV results.
// Keeps a saturating error count, first failing issue index and a sticky timeout flag per run.
module instr_seq_checker
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ERR_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [INSTR_W-1:0]     push_instr,
  input  logic [DATA_W-1:0]      push_exp_data,
  input  logic [3:0]             push_exp_flags,
  input  logic [1:0]             push_chk,
  input  logic                   start,
  output logic [INSTR_W-1:0]     cpu_instr,
  output logic                   cpu_start,
  input  logic                   cpu_waiting,
  input  logic [31:0]            cpu_status,
  input  logic [DATA_W-1:0]      cpu_datapath,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_W-1:0]       err_count,
  output logic                   first_err_valid,
  output logic [$clog2(DEPTH):0] first_err_idx,
  output logic                   timeout_seen,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] cpu_instr_q, cpu_instr_d;
  logic               cpu_start_q, cpu_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               first_err_valid_q, first_err_valid_d;
  logic [LVL_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               timeout_seen_q, timeout_seen_d;
  logic [LVL_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               to_q, to_d;

  q_entry_t           push_entry_c;
  q_entry_t           head_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic [LVL_W-1:0]   fifo_level_c;
  logic               push_acc_c;
  logic               pop_c;
  logic               mismatch_c;
  logic               status_unused_c;

  always_comb begin
    push_entry_c.instr     = Q_INSTR_W'(push_instr);
    push_entry_c.exp_data  = Q_DATA_W'(push_exp_data);
    push_entry_c.exp_flags = push_exp_flags;
    push_entry_c.chk       = push_chk;
  end

  assign push_acc_c      = push_valid & ~fifo_full_c;
  assign status_unused_c = ^cpu_status[NZCV_LO-1:0];

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(q_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_valid),
    .pop   (pop_c),
    .wdata (push_entry_c),
    .rdata (head_c),
    .level (fifo_level_c),
    .full  (fifo_full_c),
    .empty (fifo_empty_c)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d           = state_q;
    cpu_instr_d       = cpu_instr_q;
    cpu_start_d       = 1'b0;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    timeout_seen_d    = timeout_seen_q;
    idx_d             = idx_q;
    timer_d           = timer_q;
    to_d              = to_q;
    pop_c             = 1'b0;
    mismatch_c        = to_q
                      | (head_c.chk[CHK_DATA]  & (cpu_datapath != DATA_W'(head_c.exp_data)))
                      | (head_c.chk[CHK_FLAGS] & (cpu_status[NZCV_HI:NZCV_LO] != head_c.exp_flags));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_idx_d   = '0;
          timeout_seen_d    = 1'b0;
          idx_d             = '0;
          state_d           = fifo_empty_c ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cpu_instr_d = INSTR_W'(head_c.instr);
        cpu_start_d = 1'b1;
        timer_d     = '0;
        to_d        = 1'b0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is not trusted until the cpu has had a cycle to drop cpu_waiting.
        timer_d = timer_q + TMR_W'(1);
        if ((timer_q != '0) && cpu_waiting) begin
          state_d = ST_CHECK;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pop_c = 1'b1;
        idx_d = idx_q + LVL_W'(1);
        if (mismatch_c) begin
          if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_idx_d   = idx_q;
          end
        end
        if (to_q) timeout_seen_d = 1'b1;
        state_d = ((fifo_level_c > LVL_W'(1)) || push_acc_c) ? ST_ISSUE : ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      cpu_instr_q       <= '0;
      cpu_start_q       <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      timeout_seen_q    <= 1'b0;
      idx_q             <= '0;
      timer_q           <= '0;
      to_q              <= 1'b0;
    end else begin
      state_q           <= state_d;
      cpu_instr_q       <= cpu_instr_d;
      cpu_start_q       <= cpu_start_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      timeout_seen_q    <= timeout_seen_d;
      idx_q             <= idx_d;
      timer_q           <= timer_d;
      to_q              <= to_d;
    end
  end

  assign push_ready      = ~fifo_full_c;
  assign cpu_instr       = cpu_instr_q;
  assign cpu_start       = cpu_start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign timeout_seen    = timeout_seen_q;
  assign level           = fifo_level_c;

endmodule

// File: tb/tb_instr_seq_checker.sv
// Bench for instr_seq_checker: directed and random runs against a list-based result model,
// with a behavioural cpu that answers each launch after a scripted latency (or never).
module tb_instr_seq_checker;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned LVL_W   = 5;
  localparam int unsigned ERR_W   = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    logic [1:0]  chk;
    logic [31:0] resp_data;
    logic [31:0] resp_status;
    logic [3:0]  lat;
    logic        hang;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_instr;
  logic [31:0]      push_exp_data;
  logic [3:0]       push_exp_flags;
  logic [1:0]       push_chk;
  logic             start;
  logic [31:0]      cpu_instr;
  logic             cpu_start;
  logic             cpu_waiting = 1'b1;
  logic [31:0]      cpu_status = '0;
  logic [31:0]      cpu_datapath = '0;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_count;
  logic             first_err_valid;
  logic [LVL_W-1:0] first_err_idx;
  logic             timeout_seen;
  logic [LVL_W-1:0] level;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t model_q[$];
  ent_t resp_q[$];
  ent_t cpu_cur;
  int   cpu_cnt = 0;
  bit   cpu_active = 1'b0;

  always #5 clk = ~clk;

  instr_seq_checker #(
    .INSTR_W (32),
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .ERR_W   (ERR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_instr      (push_instr),
    .push_exp_data   (push_exp_data),
    .push_exp_flags  (push_exp_flags),
    .push_chk        (push_chk),
    .start           (start),
    .cpu_instr       (cpu_instr),
    .cpu_start       (cpu_start),
    .cpu_waiting     (cpu_waiting),
    .cpu_status      (cpu_status),
    .cpu_datapath    (cpu_datapath),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .timeout_seen    (timeout_seen),
    .level           (level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [1:0] chk, input bit bad_d, input bit bad_f,
                              input bit hang, input int lat);
    ent_t       e;
    logic [3:0] f;
    e.instr     = $urandom;
    e.exp_data  = $urandom;
    e.exp_flags = 4'($urandom);
    e.chk       = chk;
    e.resp_data = bad_d ? (e.exp_data ^ ($urandom | 32'h1)) : e.exp_data;
    f           = bad_f ? (e.exp_flags ^ (4'($urandom) | 4'h1)) : e.exp_flags;
    e.resp_status = {f, 28'($urandom)};
    e.lat       = 4'(lat);
    e.hang      = hang;
    return e;
  endfunction

  // Behavioural cpu: drops waiting on launch, raises it with the scripted result after lat cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      cpu_waiting = 1'b1;
      cpu_active  = 1'b0;
      resp_q.delete();
    end else if (cpu_start) begin
      check("cpu_resp_avail", 64'(resp_q.size() != 0), 64'(1));
      if (resp_q.size() != 0) begin
        cpu_cur = resp_q.pop_front();
        check("cpu_instr", 64'(cpu_instr), 64'(cpu_cur.instr));
        cpu_waiting = 1'b0;
        cpu_cnt     = int'(cpu_cur.lat);
        cpu_active  = !cpu_cur.hang;
      end
    end else if (cpu_active) begin
      if (cpu_cnt == 0) begin
        cpu_waiting  = 1'b1;
        cpu_datapath = cpu_cur.resp_data;
        cpu_status   = cpu_cur.resp_status;
        cpu_active   = 1'b0;
      end else begin
        cpu_cnt--;
      end
    end
  end

  task automatic push(input ent_t e);
    bit acc;
    acc            = (model_q.size() < DEPTH);
    push_valid     = 1'b1;
    push_instr     = e.instr;
    push_exp_data  = e.exp_data;
    push_exp_flags = e.exp_flags;
    push_chk       = e.chk;
    check("push_ready", 64'(push_ready), 64'(acc));
    @(negedge clk);
    push_valid = 1'b0;
    if (acc) begin
      model_q.push_back(e);
      resp_q.push_back(e);
    end
    check("level_after_push", 64'(level), 64'(model_q.size()));
  endtask

  // Start a run, optionally push one more entry push_at cycles in, then check all results.
  task automatic run(input string tag, input int push_at, input ent_t pe);
    ent_t lst[$];
    int   cyc;
    int   exp_cyc;
    int   errs;
    int   fidx;
    bit   to_seen;
    lst = model_q;
    model_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (cyc == push_at) begin
        push_valid     = 1'b1;
        push_instr     = pe.instr;
        push_exp_data  = pe.exp_data;
        push_exp_flags = pe.exp_flags;
        push_chk       = pe.chk;
        lst.push_back(pe);
        resp_q.push_back(pe);
      end
      @(negedge clk);
      push_valid = 1'b0;
      cyc++;
    end
    exp_cyc = 0;
    errs    = 0;
    fidx    = -1;
    to_seen = 1'b0;
    foreach (lst[i]) begin
      bit bad;
      exp_cyc += lst[i].hang ? int'(TIMEOUT) + 2 : int'(lst[i].lat) + 4;
      bad = lst[i].hang
          || (lst[i].chk[0] && lst[i].resp_data != lst[i].exp_data)
          || (lst[i].chk[1] && lst[i].resp_status[31:28] != lst[i].exp_flags);
      if (lst[i].hang) to_seen = 1'b1;
      if (bad) begin
        errs++;
        if (fidx < 0) fidx = i;
      end
    end
    check({tag, "_done_seen"}, 64'(done), 64'(1));
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_err_count"}, 64'(err_count), 64'(errs));
    check({tag, "_first_err_valid"}, 64'(first_err_valid), 64'(fidx >= 0));
    check({tag, "_first_err_idx"}, 64'(first_err_idx), 64'((fidx >= 0) ? fidx : 0));
    check({tag, "_timeout_seen"}, 64'(timeout_seen), 64'(to_seen));
    check({tag, "_level_end"}, 64'(level), 64'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_err_hold"}, 64'(err_count), 64'(errs));
  endtask

  initial begin
    ent_t e;
    ent_t dummy;
    rst_n          = 1'b0;
    push_valid     = 1'b0;
    push_instr     = '0;
    push_exp_data  = '0;
    push_exp_flags = '0;
    push_chk       = '0;
    start          = 1'b0;
    dummy          = '0;
    repeat (3) @(negedge clk);
    check("rst_push_ready", 64'(push_ready), 64'(1));
    check("rst_level", 64'(level), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_cpu_start", 64'(cpu_start), 64'(0));
    check("rst_cpu_instr", 64'(cpu_instr), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_first_err", 64'({first_err_valid, first_err_idx}), 64'(0));
    check("rst_timeout_seen", 64'(timeout_seen), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD that matches.
    e = mk(2'b11, 1'b0, 1'b0, 1'b0, 1);
    e.instr = 32'hE0900000; e.exp_data = 32'd2; e.exp_flags = 4'h0;
    e.resp_data = 32'd2; e.resp_status = 32'h0;
    push(e);
    run("add1", -1, dummy);

    // Wrong data on entry 1 of 3.
    for (int i = 0; i < 3; i++) begin
      e = mk(2'b11, 1'b0, 1'b0, 1'b0, i);
      e.exp_data  = 32'd10;
      e.resp_data = (i == 1) ? 32'd9 : 32'd10;
      push(e);
    end
    run("bad_data", -1, dummy);

    // Hung cpu then a normal entry.
    push(mk(2'b11, 1'b0, 1'b0, 1'b1, 0));
    push(mk(2'b11, 1'b0, 1'b0, 1'b0, 2));
    run("timeout", -1, dummy);

    // Masked compares, then an unmasked flag mismatch.
    push(mk(2'b01, 1'b0, 1'b1, 1'b0, 0));
    push(mk(2'b10, 1'b1, 1'b0, 1'b0, 1));
    push(mk(2'b00, 1'b1, 1'b1, 1'b0, 3));
    push(mk(2'b11, 1'b0, 1'b1, 1'b0, 0));
    run("chk_mask", -1, dummy);

    run("empty", -1, dummy);

    // Fill, overflow attempt, and a push during the run.
    for (int i = 0; i < 16; i++)
      push(mk(2'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5)));
    check("full_push_ready", 64'(push_ready), 64'(0));
    push(mk(2'b11, 1'b1, 1'b1, 1'b0, 0));
    check("full_level", 64'(level), 64'(DEPTH));
    run("fill", 20, mk(2'b11, 1'b1, 1'b0, 1'b0, 1));

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        push(mk(2'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5)));
      run("rand", -1, dummy);
    end

    // Reset during WAIT.
    push(mk(2'b11, 1'b0, 1'b0, 1'b0, 4));
    push(mk(2'b11, 1'b1, 1'b0, 1'b0, 4));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_cpu_start_pulse", 64'(cpu_start), 64'(1));
    @(negedge clk);
    check("mid_cpu_start_drop", 64'(cpu_start), 64'(0));
    check("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_level", 64'(level), 64'(0));
    check("mid_rst_cpu_start", 64'(cpu_start), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_push_ready", 64'(push_ready), 64'(1));
    rst_n = 1'b1;
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 64'(done), 64'(0));
    end

    push(mk(2'b11, 1'b0, 1'b0, 1'b0, 1));
    run("after_rst", -1, dummy);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_seq_checker.md
Name: instr_seq_checker

Overview:
Hardware instruction sequencer and result checker for the cpu core. Buffers a parametrised queue of {instruction, expected datapath value, expected NZCV flags}. On start it issues each instruction to the cpu, waits for completion and compares the cpu's datapath_out/status_out against expectations. Error count and first-failure index are kept for on-chip self-test and for regression benches.

Parameters:
INSTR_W, 32, instruction width driven to cpu
DATA_W, 32, width of datapath_out and expected data
DEPTH, 16, queue entries (power of two, >=2)
TIMEOUT, 64, max cycles to wait for cpu completion per instruction
ERR_W, 16, width of error counter (saturating)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
push_valid  in  1  enqueue request
push_ready  out  1  queue not full
push_instr  in  INSTR_W  instruction to issue
push_exp_data  in  DATA_W  expected datapath_out
push_exp_flags  in  4  expected status_out[31:28] (NZCV)
push_chk  in  2  [0]=compare data, [1]=compare flags
start  in  1  begin draining queue (level sampled in IDLE only)
cpu_instr  out  INSTR_W  instruction to cpu (held stable through WAIT)
cpu_start  out  1  one-cycle launch pulse to cpu
cpu_waiting  in  1  cpu idle/complete
cpu_status  in  32  cpu status_out
cpu_datapath  in  DATA_W  cpu datapath_out
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when run ends
err_count  out  ERR_W  mismatches + timeouts this run, saturating
first_err_valid  out  1  at least one error this run
first_err_idx  out  $clog2(DEPTH)+1  issue index of first error
timeout_seen  out  1  at least one timeout this run
level  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_n low at posedge): FSM=IDLE, queue empty, level=0, push_ready=1, cpu_instr=0, cpu_start=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_idx=0, timeout_seen=0.
- Queue: circular buffer with wr/rd pointers and a count. Push accepted when push_valid && push_ready. Push is legal in any state. Simultaneous push+pop leaves level unchanged. Push when full is ignored (push_ready=0).
- States: IDLE, ISSUE, WAIT, CHECK, FIN.
- IDLE: start=1 clears err_count, first_err_*, timeout_seen and issue index. Next state is ISSUE if level>0, else FIN.
- ISSUE (1 cycle): cpu_instr<=head.instr (registered), cpu_start=1; timer<=0; next WAIT.
- WAIT: cpu_waiting is ignored in the first WAIT cycle (cpu needs one cycle to drop it). From then on, cpu_waiting=1 -> CHECK. timer increments each cycle; timer==TIMEOUT-1 without completion -> CHECK with timeout flag set.
- CHECK (1 cycle): mismatch = timeout | (chk[0] & datapath!=exp_data) | (chk[1] & status[31:28]!=exp_flags). On mismatch: err_count+1 (saturate at all-ones); if !first_err_valid then capture issue index and set first_err_valid. Timeout sets timeout_seen. Pop head, index+1. Next state is ISSUE if the post-pop level>0 (including a push in the same cycle), else FIN.
- FIN: done=1 for exactly one cycle; next IDLE. Result outputs hold until the next start or reset.
- Issue latency: ISSUE to earliest CHECK is 3 cycles; CHECK to next ISSUE is 1 cycle.
- start outside IDLE is ignored. Reset mid-run aborts immediately: queue is flushed, cpu_start=0, no done pulse.
- Flag compare uses status_out[31:28] only; the remaining status bits are don't-care.

Decomposition:
- Shared package cpu_pkg: state enum (IDLE/ISSUE/WAIT/CHECK/FIN), NZCV bit-position constants, queue entry struct {instr, exp_data, exp_flags, chk}.
- One sub-module: seq_fifo (parametrised DEPTH/entry width; sync rst_n; push/pop/level/full/empty). The checker FSM stays in instr_seq_checker.

Test Plan:
- Reset then push 1 entry {0xE0900000 (ADD R0,R0,R0), exp 2, flags 0, chk 3}; bench cpu model returns 2/0x0 -> done pulse, err_count=0, first_err_valid=0, level=0.
- Push 3 entries; cpu returns wrong data 9 (exp 10) on entry 1 -> err_count=1, first_err_idx=1, the other two pass.
- Cpu model never raises cpu_waiting, TIMEOUT=8 -> CHECK after 8 WAIT cycles, timeout_seen=1, err_count=1, next entry still issued.
- Fill DEPTH=16 entries -> push_ready=0, 17th push ignored. Push during run when level drops -> new entry is issued in the same run, total 17 checked.
- chk=2'b01 with flag mismatch -> no error. chk=2'b10 with data mismatch -> no error. Start with empty queue -> FIN/done pulse 1 cycle after start, err_count=0.
- Assert rst_n=0 during WAIT -> next cycle IDLE, level=0, busy=0, cpu_start=0, no done pulse.
